storage_wb_copier: RTL



---
 rtl/storage_wb_copier_if.sv | 35 +++
 rtl/storage_wb_copier.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/storage_wb_copier_if.sv
// -----------------------------------------------------------------------------
// storage_wb_copier_if
// Wishbone bus bundle between the storage copier (master) and the management
// storage bridge (slave).
//   cyc     bus cycle
//   stb     [0] RW port strobe, [1] RO port strobe (never both high)
//   we      write enable
//   sel     byte select
//   adr     byte address
//   dat     write data
//   ack     per-port acknowledge, bit order matches stb
//   rw_dat  RW port read data
//   ro_dat  RO port read data
// -----------------------------------------------------------------------------
interface storage_wb_copier_if;
  logic        cyc;
  logic [1:0]  stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [1:0]  ack;
  logic [31:0] rw_dat;
  logic [31:0] ro_dat;

  modport master (
    output cyc, stb, we, sel, adr, dat,
    input  ack, rw_dat, ro_dat
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat,
    output ack, rw_dat, ro_dat
  );
endinterface

// File: rtl/storage_wb_copier.sv
// -----------------------------------------------------------------------------
// storage_wb_copier
// Wishbone initiator that copies len_i 32-bit words from a source window (RW or
// RO port of the storage bridge) to a destination window on the RW port, one
// read/write pair per word, ascending addresses, one idle GAP cycle between
// every request (the bridge re-acks a strobe that is left high).
//
// Optional build macro: STORAGE_COPY_VERIFY_EN
//   When defined, every write is followed by a RW-port readback (VRD) of the
//   destination word; a mismatch sets err_o and ends the copy.
//
// Parameters:
//   LEN_W    width of length/word-index counters (max copy 2^LEN_W-1 words)
//   TIMEOUT  cycles a strobe may stay unacknowledged before the copy aborts
//            (must be >= 4)
//
// Ports:
//   wb_clk_i   clock
//   wb_rst_i   synchronous active-high reset
//   start_i    one-cycle start pulse, sampled only in IDLE
//   src_ro_i   1 = read source from RO port, 0 = from RW port
//   src_adr_i  source byte address (word aligned), captured on start
//   dst_adr_i  destination byte address (word aligned), captured on start
//   len_i      word count, captured on start
//   busy_o     high from the cycle after an accepted start until DONE
//   done_o     one-cycle pulse at completion (success or abort)
//   err_o      sticky error (timeout / verify mismatch), cleared by next start
//   wbm        Wishbone master side of storage_wb_copier_if
// -----------------------------------------------------------------------------
module storage_wb_copier #(
  parameter int LEN_W   = 9,
  parameter int TIMEOUT = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_i,
  input  logic             src_ro_i,
  input  logic [31:0]      src_adr_i,
  input  logic [31:0]      dst_adr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  storage_wb_copier_if.master wbm
);

  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

`ifdef STORAGE_COPY_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_GAP_RD  = 3'd2,
    S_WR      = 3'd3,
    S_GAP_WR  = 3'd4,
    S_VRD     = 3'd5,
    S_GAP_VRD = 3'd6,
    S_DONE    = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_GAP_RD = 3'd2,
    S_WR     = 3'd3,
    S_GAP_WR = 3'd4,
    S_DONE   = 3'd7
  } state_t;
`endif

  state_t state, state_n;

  // Captured job and datapath registers
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [LEN_W-1:0] len_q;
  logic             src_ro_q;
  logic [LEN_W-1:0] idx;
  logic [31:0]      data_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  // Control strobes from the next-state logic to the datapath
  logic accept;
  logic latch;
  logic idx_inc;
  logic set_err;

  // Bus drive values
  logic        cyc;
  logic [1:0]  stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat;

  logic [31:0] src_word_adr;
  logic [31:0] dst_word_adr;
  logic [1:0]  rd_port;
  logic        last_word;
  logic        tmo_expired;

  // Word index scaled to a byte offset; sums wrap modulo 2^32.
  assign src_word_adr = src_q + (32'(idx) << 2);
  assign dst_word_adr = dst_q + (32'(idx) << 2);
  assign rd_port      = src_ro_q ? 2'b10 : 2'b01;
  assign last_word    = (idx == (len_q - LEN_W'(1)));
  assign tmo_expired  = (tmo_cnt == TMO_W'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    latch   = 1'b0;
    idx_inc = 1'b0;
    set_err = 1'b0;
    cyc     = 1'b0;
    stb     = 2'b00;
    we      = 1'b0;
    sel     = 4'h0;
    adr     = 32'h0;
    dat     = 32'h0;
    busy_o  = 1'b0;
    done_o  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_n = (len_i == '0) ? S_DONE : S_RD;
        end
      end

      S_RD: begin
        busy_o = 1'b1;
        cyc    = 1'b1;
        stb    = rd_port;
        adr    = src_word_adr;
        // Only the ack bit of the strobed port completes the read.
        if (|(wbm.ack & rd_port)) begin
          latch   = 1'b1;
          state_n = S_GAP_RD;
        end else if (tmo_expired) begin
          set_err = 1'b1;
          state_n = S_DONE;
        end
      end

      S_GAP_RD: begin
        busy_o  = 1'b1;
        state_n = S_WR;
      end

      S_WR: begin
        busy_o = 1'b1;
        cyc    = 1'b1;
        stb    = 2'b01;
        we     = 1'b1;
        sel    = 4'hF;
        adr    = dst_word_adr;
        dat    = data_q;
        if (wbm.ack[0]) begin
          state_n = S_GAP_WR;
        end else if (tmo_expired) begin
          set_err = 1'b1;
          state_n = S_DONE;
        end
      end

      S_GAP_WR: begin
        busy_o = 1'b1;
`ifdef STORAGE_COPY_VERIFY_EN
        state_n = S_VRD;
`else
        if (last_word) begin
          state_n = S_DONE;
        end else begin
          idx_inc = 1'b1;
          state_n = S_RD;
        end
`endif
      end

`ifdef STORAGE_COPY_VERIFY_EN
      S_VRD: begin
        busy_o = 1'b1;
        cyc    = 1'b1;
        stb    = 2'b01;
        adr    = dst_word_adr;
        if (wbm.ack[0]) begin
          if (wbm.rw_dat != data_q) begin
            set_err = 1'b1;
            state_n = S_DONE;
          end else begin
            state_n = S_GAP_VRD;
          end
        end else if (tmo_expired) begin
          set_err = 1'b1;
          state_n = S_DONE;
        end
      end

      S_GAP_VRD: begin
        busy_o = 1'b1;
        if (last_word) begin
          state_n = S_DONE;
        end else begin
          idx_inc = 1'b1;
          state_n = S_RD;
        end
      end
`endif

      S_DONE: begin
        done_o  = 1'b1;
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      src_q    <= 32'h0;
      dst_q    <= 32'h0;
      len_q    <= '0;
      src_ro_q <= 1'b0;
      idx      <= '0;
      data_q   <= 32'h0;
      tmo_cnt  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        src_q    <= src_adr_i;
        dst_q    <= dst_adr_i;
        len_q    <= len_i;
        src_ro_q <= src_ro_i;
        idx      <= '0;
        err_q    <= 1'b0;
      end
      if (latch) begin
        data_q <= src_ro_q ? wbm.ro_dat : wbm.rw_dat;
      end
      if (idx_inc) begin
        idx <= idx + LEN_W'(1);
      end
      if (set_err) begin
        err_q <= 1'b1;
      end
      // Counts cycles of the current strobe; the GAP before every request
      // returns it to zero, so each new strobe starts its own budget.
      tmo_cnt <= cyc ? tmo_cnt + TMO_W'(1) : '0;
    end
  end

  assign err_o   = err_q;
  assign wbm.cyc = cyc;
  assign wbm.stb = stb;
  assign wbm.we  = we;
  assign wbm.sel = sel;
  assign wbm.adr = adr;
  assign wbm.dat = dat;

endmodule
